// File: rtl/program_loader_tx.sv
// Transmit side of the CPU program-load handshake: holds a host-written image and
// streams it as {address, data} byte pairs, paced on the CPU's ready/done outputs.
module program_loader_tx #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          img_we,
    input  logic [AW-1:0] img_addr,
    input  logic [7:0]    img_data,
    input  logic          start,
    input  logic          ready_i,
    input  logic          done_i,
    output logic          programming_o,
    output logic [7:0]    byte_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic [AW+1:0] sent_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    localparam logic [AW+1:0] LAST_IDX  = (AW+2)'(2*DEPTH-1);
    localparam logic [7:0]    TIMEOUT_V = 8'(TIMEOUT);

    logic [7:0]    r_mem [DEPTH];
    state_t        r_state;
    logic          r_ready_q;
    logic [7:0]    r_timer;
    logic          r_prog;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [7:0]    r_byte;
    logic [AW+1:0] r_sent;

    logic          w_rise;
    logic          w_last;
    logic          w_timeout;
    logic [AW+1:0] w_next_idx;
    logic [7:0]    w_next_byte;

    // Consumption strobe, end-of-stream and timeout detection
    always_comb begin
        w_rise    = ready_i & ~r_ready_q;
        w_last    = (r_sent == LAST_IDX);
        w_timeout = (TIMEOUT != 0) && (r_timer == TIMEOUT_V);
    end

    // Next byte in stream order: even index carries the address, odd index the image word
    always_comb begin
        w_next_idx  = r_sent + (AW+2)'(1);
        w_next_byte = 8'h00;
        if (w_last) begin
            w_next_byte = 8'h00;
        end else if (w_next_idx[0]) begin
            w_next_byte = r_mem[w_next_idx[AW:1]];
        end else begin
            w_next_byte = 8'(w_next_idx[AW:1]);
        end
    end

    // Image storage; host writes only land while idle, contents survive reset
    always_ff @(posedge clk) begin
        if (img_we && (r_state == S_IDLE)) begin
            r_mem[img_addr] <= img_data;
        end
    end

    // Transfer FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready_q <= 1'b0;
            r_timer   <= 8'd0;
            r_prog    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_byte    <= 8'h00;
            r_sent    <= '0;
        end else begin
            r_ready_q <= ready_i;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ARM;
                        r_prog  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_error <= 1'b0;
                        r_sent  <= '0;
                        r_byte  <= 8'h00;
                        r_timer <= 8'd0;
                    end
                end
                // One full cycle of programming before any byte may be taken
                S_ARM: begin
                    r_state <= S_SEND;
                    r_timer <= 8'd0;
                end
                S_SEND: begin
                    if (w_rise) begin
                        r_sent  <= r_sent + (AW+2)'(1);
                        r_byte  <= w_next_byte;
                        r_timer <= 8'd0;
                        if (w_last) begin
                            r_state <= S_WAIT_DONE;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERROR;
                        r_prog  <= 1'b0;
                        r_error <= 1'b1;
                        r_timer <= 8'd0;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (done_i) begin
                        r_state <= S_FINISH;
                        r_prog  <= 1'b0;
                        r_done  <= 1'b1;
                        r_timer <= 8'd0;
                    end else if (w_timeout) begin
                        r_state <= S_ERROR;
                        r_prog  <= 1'b0;
                        r_error <= 1'b1;
                        r_timer <= 8'd0;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_ERROR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_prog  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_timer <= 8'd0;
                end
            endcase
        end
    end

    assign programming_o = r_prog;
    assign byte_o        = r_byte;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign error_o       = r_error;
    assign sent_o        = r_sent;

endmodule

// File: tb/tb_program_loader_tx.sv
// Bench for program_loader_tx: a CPU-side model pops expected bytes from a scoreboard
// queue filled at each start and checks byte_o just before raising ready.
module tb_program_loader_tx;

    localparam int DEPTH = 16;
    localparam int TO    = 20;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          img_we;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_data;
    logic          start;
    logic          ready_i;
    logic          done_i;
    logic          programming_o;
    logic [7:0]    byte_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [AW+1:0] sent_o;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] img_m [DEPTH];
    logic [7:0] exp_q [$];

    program_loader_tx #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .img_we        (img_we),
        .img_addr      (img_addr),
        .img_data      (img_data),
        .start         (start),
        .ready_i       (ready_i),
        .done_i        (done_i),
        .programming_o (programming_o),
        .byte_o        (byte_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .sent_o        (sent_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Optionally write image[0] in the same cycle as start; leaves the DUT in SEND
    task automatic do_start(input logic we, input logic [7:0] d);
        if (we) begin
            img_we   = 1'b1;
            img_addr = 4'd0;
            img_data = d;
            img_m[0] = d;
        end
        exp_q.delete();
        for (int k = 0; k < 2*DEPTH; k++) begin
            if (k % 2 == 1) exp_q.push_back(img_m[k/2]);
            else            exp_q.push_back(8'(k/2));
        end
        start = 1'b1;
        tick();
        start  = 1'b0;
        img_we = 1'b0;
        chk("arm_prog", 32'(programming_o), 32'd1);
        chk("arm_busy", 32'(busy_o), 32'd1);
        tick();
    endtask

    task automatic cpu_byte(input int hi, input int lo);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("byte%0d", 2*DEPTH - 1 - exp_q.size()), 32'(byte_o), 32'(e));
        end
        ready_i = 1'b1;
        repeat (hi) tick();
        ready_i = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic finish_xfer();
        int n;
        chk("sent", 32'(sent_o), 32'd32);
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        chk("no_early_done", 32'(done_o), 32'd0);
        chk("prog_wait", 32'(programming_o), 32'd1);
        done_i = 1'b1;
        n = 0;
        while (!done_o && n < 50) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_o), 32'd1);
        chk("prog_fin", 32'(programming_o), 32'd0);
        done_i = 1'b0;
        tick();
        chk("done_pulse", 32'(done_o), 32'd0);
        chk("busy_idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        img_we   = 1'b0;
        img_addr = '0;
        img_data = 8'h00;
        start    = 1'b0;
        ready_i  = 1'b0;
        done_i   = 1'b0;
        #23;
        chk("rst_prog",  32'(programming_o), 32'd0);
        chk("rst_byte",  32'(byte_o),  32'd0);
        chk("rst_busy",  32'(busy_o),  32'd0);
        chk("rst_done",  32'(done_o),  32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_sent",  32'(sent_o),  32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            img_we   = 1'b1;
            img_addr = AW'(i);
            img_data = 8'hA0 + 8'(i);
            img_m[i] = 8'hA0 + 8'(i);
            tick();
        end
        img_we = 1'b0;

        // T1: ready pulsed every 3 cycles
        do_start(1'b0, 8'h00);
        for (int k = 0; k < 2*DEPTH; k++) cpu_byte(1, 2);
        finish_xfer();

        // T2: ready held high 10 cycles per byte; image[0] rewritten alongside start
        do_start(1'b1, 8'h5A);
        for (int k = 0; k < 2*DEPTH; k++) cpu_byte(10, 2);
        finish_xfer();

        // T3: no ready at all -> timeout
        do_start(1'b0, 8'h00);
        n = 0;
        while (!error_o && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", 32'(n), 32'd21);
        chk("to_prog", 32'(programming_o), 32'd0);
        tick();
        chk("to_busy", 32'(busy_o), 32'd0);
        chk("to_sticky", 32'(error_o), 32'd1);

        // T4: restart clears error, then reset after 5 bytes
        do_start(1'b0, 8'h00);
        chk("err_clr", 32'(error_o), 32'd0);
        for (int k = 0; k < 5; k++) cpu_byte(1, 1);
        chk("mid_sent", 32'(sent_o), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_prog", 32'(programming_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_sent", 32'(sent_o), 32'd0);
        chk("arst_byte", 32'(byte_o), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        do_start(1'b0, 8'h00);
        for (int k = 0; k < 2*DEPTH; k++) cpu_byte(1, 2);
        finish_xfer();

        // T5: write/start/early done_i while busy are all ignored
        do_start(1'b0, 8'h00);
        for (int k = 0; k < 2*DEPTH; k++) begin
            cpu_byte(1, 2);
            if (k == 8) begin
                img_we   = 1'b1;
                img_addr = 4'd12;
                img_data = 8'h55;
                start    = 1'b1;
                tick();
                img_we = 1'b0;
                start  = 1'b0;
            end
            if (k == 12) begin
                done_i = 1'b1;
                tick();
                tick();
                done_i = 1'b0;
                tick();
                chk("early_done_busy", 32'(busy_o), 32'd1);
                chk("early_done_prog", 32'(programming_o), 32'd1);
            end
        end
        finish_xfer();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
